// File: rtl/instr_fetch_reg.sv
// Two-byte instruction register: fetches a high then a low byte from the data bus and holds the result.
// Optional per-byte parity checking is compiled in with `define INSTR_FETCH_PARITY_EN.
module instr_fetch_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OP_BITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               data,
  input  logic                           data_valid,
  input  logic                           data_par,
  input  logic                           ir_ready,
  output logic [OP_BITS-1:0]             opcode,
  output logic [2*WIDTH-OP_BITS-1:0]     ir_addr,
  output logic                           ir_valid,
  output logic                           busy,
  output logic                           par_err
);

  localparam int unsigned IR_W   = 2 * WIDTH;
  localparam int unsigned ADDR_W = IR_W - OP_BITS;

  typedef enum logic [1:0] {IDLE, HI, LO, FULL} state_t;

  state_t            state;
  logic [IR_W-1:0]   ir;

  // Opcode and address are straight slices of the instruction flops.
  assign opcode  = ir[IR_W-1 -: OP_BITS];
  assign ir_addr = ir[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ir       <= '0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
    end else if (flush) begin
      // Abort keeps ir contents; only the control state is dropped.
      state    <= IDLE;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch) begin
            state <= HI;
            busy  <= 1'b1;
          end
        end
        HI: begin
          if (data_valid) begin
            ir[IR_W-1:WIDTH] <= data;
            state            <= LO;
          end
        end
        LO: begin
          if (data_valid) begin
            ir[WIDTH-1:0] <= data;
            state         <= FULL;
            busy          <= 1'b0;
            ir_valid      <= 1'b1;
          end
        end
        FULL: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            if (fetch) begin
              state <= HI;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ir_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_FETCH_PARITY_EN
  logic byte_err;
  logic start_fetch;

  assign byte_err    = (^data) ^ data_par;
  assign start_fetch = fetch && ((state == IDLE) || ((state == FULL) && ir_ready));

  // Sticky per-instruction error, cleared when the next fetch is accepted.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      par_err <= 1'b0;
    end else if (start_fetch) begin
      par_err <= 1'b0;
    end else if (((state == HI) || (state == LO)) && data_valid && byte_err) begin
      par_err <= 1'b1;
    end
  end
`else
  logic unused_data_par;
  assign unused_data_par = data_par;
  assign par_err         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: directed scenarios plus randomized traffic against a byte-level model.
module tb_instr_fetch_reg;

  logic        clk = 1'b0;
  logic        rst, fetch, flush, data_valid, data_par, ir_ready;
  logic [7:0]  data;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic        ir_valid, busy, par_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: "waiting for byte k of an instruction" plus a held-word flag.
  bit          m_fetching;
  int          m_bytes_got;
  bit          m_held;
  bit          m_par;
  logic [15:0] m_ir;

  instr_fetch_reg #(.WIDTH(8), .OP_BITS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (fetch),
    .flush      (flush),
    .data       (data),
    .data_valid (data_valid),
    .data_par   (data_par),
    .ir_ready   (ir_ready),
    .opcode     (opcode),
    .ir_addr    (ir_addr),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  function automatic bit byte_bad(input logic [7:0] d, input logic p);
`ifdef INSTR_FETCH_PARITY_EN
    return ((^d) ^ p) == 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic cyc(input logic r, input logic f, input logic fl, input logic dv,
                     input logic [7:0] d, input logic dp, input logic rdy);
    rst = r; fetch = f; flush = fl; data_valid = dv; data = d; data_par = dp; ir_ready = rdy;
    if (r) begin
      m_fetching = 0; m_bytes_got = 0; m_held = 0; m_par = 0; m_ir = 16'h0000;
    end else if (fl) begin
      m_fetching = 0; m_held = 0; m_par = 0;
    end else if (m_held) begin
      if (rdy) begin
        m_held = 0;
        if (f) begin m_fetching = 1; m_bytes_got = 0; m_par = 0; end
      end
    end else if (m_fetching) begin
      if (dv) begin
        if (m_bytes_got == 0) m_ir = {d, m_ir[7:0]};
        else                  m_ir = {m_ir[15:8], d};
        if (byte_bad(d, dp)) m_par = 1;
        m_bytes_got = m_bytes_got + 1;
        if (m_bytes_got == 2) begin m_fetching = 0; m_held = 1; end
      end
    end else if (f) begin
      m_fetching = 1; m_bytes_got = 0; m_par = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 1, 8'hFF, 1, 1);
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid got %b want 0", ir_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (opcode !== 3'b000) $display("FAIL reset_opcode got %b want 000", opcode); else n_pass++;
    n_checks++; if (ir_addr !== 13'h0000) $display("FAIL reset_ir_addr got %h want 0000", ir_addr); else n_pass++;
    n_checks++; if (par_err !== 1'b0) $display("FAIL reset_par_err got %b want 0", par_err); else n_pass++;
  endtask

  task automatic test_basic_fetch;
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    n_checks++; if (busy !== 1'b1 || ir_valid !== 1'b0)
      $display("FAIL basic_hi busy=%b ir_valid=%b want 1/0", busy, ir_valid); else n_pass++;
    cyc(0, 0, 0, 1, 8'hA5, 0, 0);
    n_checks++; if (busy !== 1'b1 || ir_valid !== 1'b0)
      $display("FAIL basic_lo busy=%b ir_valid=%b want 1/0", busy, ir_valid); else n_pass++;
    cyc(0, 0, 0, 1, 8'h3C, 0, 0);
    n_checks++; if (ir_valid !== 1'b1) $display("FAIL basic_ir_valid got %b want 1", ir_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (opcode !== 3'b101) $display("FAIL basic_opcode got %b want 101", opcode); else n_pass++;
    n_checks++; if (ir_addr !== 13'h053C) $display("FAIL basic_ir_addr got %h want 053c", ir_addr); else n_pass++;
    // Held word must ignore stray fetch and data_valid while not consumed.
    cyc(0, 1, 0, 1, 8'h77, 0, 0);
    n_checks++; if (ir_valid !== 1'b1 || opcode !== 3'b101 || ir_addr !== 13'h053C)
      $display("FAIL basic_hold ir_valid=%b opcode=%b ir_addr=%h want 1/101/053c", ir_valid, opcode, ir_addr);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    cyc(0, 1, 0, 0, 8'h00, 0, 1);
    n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_first ir_valid=%b busy=%b want 0/1", ir_valid, busy); else n_pass++;
    cyc(0, 0, 0, 1, 8'h12, 0, 0);
    n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_second ir_valid=%b busy=%b want 0/1", ir_valid, busy); else n_pass++;
    cyc(0, 0, 0, 1, 8'h34, 0, 0);
    n_checks++; if (ir_valid !== 1'b1 || opcode !== 3'b000 || ir_addr !== 13'h1234)
      $display("FAIL b2b_word ir_valid=%b opcode=%b ir_addr=%h want 1/000/1234", ir_valid, opcode, ir_addr);
    else n_pass++;
  endtask

  task automatic test_flush;
    cyc(0, 0, 1, 0, 8'h00, 0, 0);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 8'hFF, 0, 0);
    cyc(0, 1, 1, 1, 8'hEE, 0, 1);
    n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_ctrl ir_valid=%b busy=%b want 0/0", ir_valid, busy); else n_pass++;
    n_checks++; if (opcode !== 3'b111 || ir_addr !== 13'h1F34)
      $display("FAIL flush_retain opcode=%b ir_addr=%h want 111/1f34", opcode, ir_addr); else n_pass++;
    cyc(0, 0, 0, 1, 8'h99, 0, 0);
    n_checks++; if (busy !== 1'b0 || ir_addr !== 13'h1F34)
      $display("FAIL flush_idle_dv busy=%b ir_addr=%h want 0/1f34", busy, ir_addr); else n_pass++;
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 8'h40, 1, 0);
    cyc(0, 0, 0, 1, 8'h01, 1, 0);
    n_checks++; if (ir_valid !== 1'b1 || opcode !== 3'b010 || ir_addr !== 13'h0001)
      $display("FAIL flush_refetch ir_valid=%b opcode=%b ir_addr=%h want 1/010/0001", ir_valid, opcode, ir_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch;
    cyc(0, 0, 1, 0, 8'h00, 0, 0);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 8'h77, 0, 0);
    cyc(1, 1, 1, 1, 8'h99, 0, 1);
    n_checks++; if ({opcode, ir_addr, ir_valid, busy, par_err} !== 19'h0)
      $display("FAIL rst_mid opcode=%b ir_addr=%h ir_valid=%b busy=%b par_err=%b want all 0",
               opcode, ir_addr, ir_valid, busy, par_err);
    else n_pass++;
    cyc(0, 0, 0, 1, 8'h55, 1, 0);
    n_checks++; if ({opcode, ir_addr, ir_valid, busy, par_err} !== 19'h0)
      $display("FAIL rst_mid_dv opcode=%b ir_addr=%h ir_valid=%b busy=%b par_err=%b want all 0",
               opcode, ir_addr, ir_valid, busy, par_err);
    else n_pass++;
  endtask

  task automatic test_parity;
    bit exp_err;
`ifdef INSTR_FETCH_PARITY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 8'h01, 0, 0);
    n_checks++; if (par_err !== exp_err) $display("FAIL par_hi got %b want %b", par_err, exp_err); else n_pass++;
    cyc(0, 0, 0, 1, 8'h02, 1, 0);
    n_checks++; if (par_err !== exp_err || ir_valid !== 1'b1)
      $display("FAIL par_full par_err=%b ir_valid=%b want %b/1", par_err, ir_valid, exp_err); else n_pass++;
    cyc(0, 1, 0, 0, 8'h00, 0, 1);
    n_checks++; if (par_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL par_clear par_err=%b busy=%b want 0/1", par_err, busy); else n_pass++;
  endtask

  task automatic test_random;
    int errs_before;
    errs_before = n_checks - n_pass;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 31) == 0),
          $urandom_range(0, 1) == 1, 8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
      n_checks++;
      if ({opcode, ir_addr, ir_valid, busy, par_err} !== {m_ir, m_held, m_fetching, m_par}) begin
        if ((n_checks - n_pass) - errs_before < 10)
          $display("FAIL random_cycle%0d got ir=%h v=%b b=%b p=%b want ir=%h v=%b b=%b p=%b",
                   i, {opcode, ir_addr}, ir_valid, busy, par_err, m_ir, m_held, m_fetching, m_par);
      end else begin
        n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; flush = 1'b0; data_valid = 1'b0; data = 8'h00; data_par = 1'b0; ir_ready = 1'b0;
    m_fetching = 0; m_bytes_got = 0; m_held = 0; m_par = 0; m_ir = 16'h0000;
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_flush();
    test_reset_mid_fetch();
    test_parity();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_reg.md
INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bus width in bits; the instruction is 2*WIDTH bits.
REQ-002 SHALL have parameter OP_BITS, default 3, opcode field width; address field width is 2*WIDTH-OP_BITS (13 at defaults).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fetch  input  1  request to fetch one instruction.
REQ-006 flush  input  1  synchronous abort of any fetch or held instruction.
REQ-007 data  input  WIDTH  byte from memory data bus.
REQ-008 data_valid  input  1  data carries a valid byte this cycle.
REQ-009 data_par  input  1  parity bit accompanying data; used only when the parity feature is compiled in.
REQ-010 ir_ready  input  1  downstream controller consumes the held instruction.
REQ-011 opcode  output  OP_BITS  ir[2*WIDTH-1 -: OP_BITS], registered.
REQ-012 ir_addr  output  2*WIDTH-OP_BITS  low field of ir, registered; feeds the address-select mux input for the instruction operand address.
REQ-013 ir_valid  output  1  complete instruction held.
REQ-014 busy  output  1  fetch in progress (state HI or LO).
REQ-015 par_err  output  1  parity error seen on the current instruction.

Function
REQ-016 SHALL implement states IDLE, HI, LO and FULL.
REQ-017 IDLE: fetch=1 -> HI; otherwise stay in IDLE.
REQ-018 HI: data_valid=1 -> ir[2*WIDTH-1:WIDTH] <= data, -> LO; otherwise hold, with no timeout.
REQ-019 LO: data_valid=1 -> ir[WIDTH-1:0] <= data, -> FULL; otherwise hold.
REQ-020 FULL: ir_valid=1; ir_ready=1 and fetch=1 -> HI (back-to-back); ir_ready=1 alone -> IDLE; otherwise hold.
REQ-021 busy SHALL be 1 exactly in HI and LO; ir_valid SHALL be 1 exactly in FULL.
REQ-022 fetch SHALL be ignored in HI and LO, and in FULL while ir_ready=0.
REQ-023 data_valid SHALL be ignored in IDLE and FULL.
REQ-024 Minimum latency: fetch in cycle N with data_valid in N+1 and N+2 gives ir_valid=1 in N+3.
REQ-025 opcode and ir_addr SHALL be stable whenever ir_valid=1, and SHALL change only on a byte capture.
REQ-026 flush=1 SHALL force IDLE on the next edge from any state, dropping ir_valid and busy; ir contents SHALL be retained; flush SHALL override fetch, data_valid and ir_ready.
REQ-027 The high byte of a new fetch SHALL overwrite ir[15:8] while ir[7:0] still holds the previous instruction; consumers SHALL rely on opcode and ir_addr only while ir_valid=1.

Reset
REQ-028 rst=1 on a rising edge SHALL set state=IDLE, ir=0, opcode=0, ir_addr=0, ir_valid=0, busy=0 and par_err=0.
REQ-029 rst SHALL take priority over flush and all other inputs, including in the middle of a fetch.

Configuration
REQ-030 Macro INSTR_FETCH_PARITY_EN SHALL select the parity feature.
REQ-031 With INSTR_FETCH_PARITY_EN defined, each captured byte is checked: (^data ^ data_par) != 0 sets par_err.
- par_err SHALL stay set until the next transition IDLE/FULL -> HI, rst, or flush.
- ir_valid SHALL still be asserted on a parity error.
REQ-032 With INSTR_FETCH_PARITY_EN undefined, par_err SHALL be constant 0, data_par SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-033 rst, then fetch in cycle 1, data 0xA5 in cycle 2 and 0x3C in cycle 3 (data_valid=1) -> ir_valid=1 in cycle 4, opcode=3'b101, ir_addr=13'h053C, busy=0.
REQ-034 Instruction held, then ir_ready=1 and fetch=1 in the same cycle, then bytes 0x12 and 0x34 -> ir_valid drops for 2 cycles, then opcode=3'b000 and ir_addr=13'h1234.
REQ-035 fetch, byte 0xFF, then flush -> IDLE next cycle, ir_valid=0, busy=0; a later clean fetch of 0x40, 0x01 gives opcode=3'b010 and ir_addr=13'h0001.
REQ-036 rst asserted while in LO -> all outputs 0 on the next edge; data_valid in the following cycle is ignored.
REQ-037 With INSTR_FETCH_PARITY_EN: byte 0x01 with data_par=0 -> par_err=1 with ir_valid=1, and par_err=0 after the next fetch is accepted. Without the macro: par_err=0 throughout.
